// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding and width helper for the FIFO write arbiter
package fifo_arb_pkg;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker: first valid requester searching upward from rr_ptr with wrap, one-hot
module rr_picker import fifo_arb_pkg::*; #(
    parameter int NUM_REQ = 2,
    localparam int PW = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               any_valid
);
    // Scan distances from farthest to nearest so the nearest valid index wins
    always_comb begin
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            for (int j = 0; j < NUM_REQ; j++)
                if (req_valid[j] && j == (int'(rr_ptr) + k) % NUM_REQ) begin
                    pick = '0;
                    pick[j] = 1'b1;
                end
        any_valid = |req_valid;
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter for the FIFO write port; FIFO_ARB_STALL_CNT_EN adds stall_cnt/stall_clr
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2,
    parameter int BURST_MAX  = 4,
    parameter int IDLE_TMO   = 15
) (
    input  logic                          W_CLK,
    input  logic                          W_RST,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    input  logic                          stall_clr,
    output logic [15:0]                   stall_cnt
`endif
);
    localparam int PW = clog2(NUM_REQ);
    localparam int BW = clog2(BURST_MAX);
    localparam int TW = clog2(IDLE_TMO);
    arb_state_t state;
    logic [PW-1:0] rr_ptr, ptr_nxt;
    logic [BW-1:0] beat_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [NUM_REQ-1:0] pick;
    logic any_valid, valid_g, last_g, done;
    logic [DATA_WIDTH-1:0] data_g;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_valid(req_valid),
        .rr_ptr   (rr_ptr),
        .pick     (pick),
        .any_valid(any_valid)
    );

    // Owner's data word and the round-robin pointer just past the owner
    always_comb begin
        data_g = '0;
        ptr_nxt = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) begin
                data_g = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                ptr_nxt = PW'((i + 1) % NUM_REQ);
            end
    end

    assign valid_g   = |(req_valid & grant);
    assign last_g    = |(req_last & grant);
    assign busy      = state == ARB_BUSY;
    assign winc      = busy && valid_g && !wfull;
    assign req_ready = (busy && !wfull) ? grant : '0;
    assign w_data    = winc ? data_g : '0;
    assign done      = (winc && (last_g || beat_cnt == BW'(BURST_MAX - 1))) ||
                       (busy && !wfull && !valid_g && tmo_cnt == TW'(IDLE_TMO - 1));

    // Arbitration FSM: grant on the edge after a pick, release on last/burst limit/timeout; wfull freezes everything
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            state    <= ARB_IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            tmo_cnt  <= '0;
        end else if (!busy) begin
            if (any_valid) begin
                state <= ARB_BUSY;
                grant <= pick;
            end
        end else if (done) begin
            state    <= ARB_IDLE;
            grant    <= '0;
            rr_ptr   <= ptr_nxt;
            beat_cnt <= '0;
            tmo_cnt  <= '0;
        end else if (!wfull) begin
            if (winc) beat_cnt <= beat_cnt + BW'(1);
            tmo_cnt <= valid_g ? '0 : tmo_cnt + TW'(1);
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    // Saturating count of cycles where the owner has data but the FIFO is full
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) stall_cnt <= '0;
        else if (stall_clr) stall_cnt <= '0;
        else if (busy && valid_g && wfull && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vector bench for fifo_wr_arbiter (2- and 4-requester builds)
module tb_fifo_wr_arbiter;
    typedef struct {
        logic       rst;
        logic [1:0] valid;
        logic [1:0] last;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       wfull;
        logic [1:0] g;
        logic [1:0] rdy;
        logic       winc;
        logic [7:0] wd;
        logic       busy;
    } vec_t;

    logic W_CLK = 1'b0;
    logic W_RST;
    logic [1:0] req_valid, req_last, req_ready, grant;
    logic [15:0] req_data;
    logic wfull, winc, busy;
    logic [7:0] w_data;
    logic [3:0] v4_valid, v4_last, v4_ready, v4_grant;
    logic [31:0] v4_data;
    logic v4_winc, v4_busy;
    logic [7:0] v4_wdata;
`ifdef FIFO_ARB_STALL_CNT_EN
    logic stall_clr;
    logic [15:0] stall_cnt, v4_stall_cnt;
`endif
    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[10];

    always #5 W_CLK = ~W_CLK;

    fifo_wr_arbiter u_dut (
        .W_CLK(W_CLK), .W_RST(W_RST), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .wfull(wfull), .winc(winc),
        .w_data(w_data), .grant(grant), .busy(busy)
`ifdef FIFO_ARB_STALL_CNT_EN
        , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
    );

    fifo_wr_arbiter #(.NUM_REQ(4)) u_dut4 (
        .W_CLK(W_CLK), .W_RST(W_RST), .req_valid(v4_valid), .req_last(v4_last),
        .req_data(v4_data), .req_ready(v4_ready), .wfull(1'b0), .winc(v4_winc),
        .w_data(v4_wdata), .grant(v4_grant), .busy(v4_busy)
`ifdef FIFO_ARB_STALL_CNT_EN
        , .stall_clr(1'b0), .stall_cnt(v4_stall_cnt)
`endif
    );

    function automatic vec_t mk(input logic rst, input logic [1:0] valid, input logic [1:0] last,
                                input logic [7:0] d0, input logic [7:0] d1, input logic wf,
                                input logic [1:0] g, input logic [1:0] rdy, input logic wi,
                                input logic [7:0] wd, input logic bz);
        vec_t v;
        v = '{rst, valid, last, d0, d1, wf, g, rdy, wi, wd, bz};
        return v;
    endfunction

    task automatic step(input vec_t v, input string name);
        @(negedge W_CLK);
        W_RST = !v.rst;
        req_valid = v.valid;
        req_last = v.last;
        req_data = {v.d1, v.d0};
        wfull = v.wfull;
        #2;
        n_vec++;
        if (grant !== v.g || req_ready !== v.rdy || winc !== v.winc || w_data !== v.wd || busy !== v.busy) begin
            n_err++;
            $display("FAIL %s: got grant=%b ready=%b winc=%b w_data=%h busy=%b, want %b %b %b %h %b",
                     name, grant, req_ready, winc, w_data, busy, v.g, v.rdy, v.winc, v.wd, v.busy);
        end
    endtask

    task automatic step4(input logic [3:0] valid, input logic [3:0] eg, input logic ew, input logic [7:0] ed,
                         input string name);
        @(negedge W_CLK);
        v4_valid = valid;
        v4_last = valid;
        #2;
        n_vec++;
        if (v4_grant !== eg || v4_winc !== ew || v4_wdata !== ed || v4_ready !== eg) begin
            n_err++;
            $display("FAIL %s: got grant=%b winc=%b w_data=%h ready=%b, want %b %b %h %b",
                     name, v4_grant, v4_winc, v4_wdata, v4_ready, eg, ew, ed, eg);
        end
    endtask

    initial begin
        logic [1:0] eg;
        logic [7:0] c8;
        W_RST = 1'b0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        wfull = 1'b0;
        v4_valid = '0;
        v4_last = '0;
        v4_data = 32'h44332211;
`ifdef FIFO_ARB_STALL_CNT_EN
        stall_clr = 1'b0;
`endif
        // single req0 burst of three, then req1 picked first because rr_ptr moved to 1
        tbl[0] = '{1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 2'b01, 2'b00, 8'hA1, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 2'b01, 2'b00, 8'hA1, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'hA1, 1'b1};
        tbl[4] = '{1'b0, 2'b01, 2'b00, 8'hB2, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'hB2, 1'b1};
        tbl[5] = '{1'b0, 2'b01, 2'b01, 8'hC3, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'hC3, 1'b1};
        tbl[6] = '{1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[7] = '{1'b0, 2'b11, 2'b10, 8'h11, 8'h55, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[8] = '{1'b0, 2'b11, 2'b10, 8'h11, 8'h55, 1'b0, 2'b10, 2'b10, 1'b1, 8'h55, 1'b1};
        tbl[9] = '{1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0};
        for (int i = 0; i < 10; i++) step(tbl[i], $sformatf("table[%0d]", i));
        // both requesters streaming with no last: 4-beat bursts alternating with a bubble between
        for (int c = 0; c < 15; c++) begin
            c8 = 8'(c);
            eg = (c == 0 || c == 5 || c == 10) ? 2'b00 : (c > 5 && c < 10) ? 2'b10 : 2'b01;
            step(mk(1'b0, 2'b11, 2'b00, c8, c8 + 8'h80, 1'b0, eg, eg, eg != 2'b00,
                    eg == 2'b01 ? c8 : eg == 2'b10 ? c8 + 8'h80 : 8'h00, eg != 2'b00),
                 $sformatf("alternate[%0d]", c));
        end
        // wfull held 5 cycles mid-burst: no beats, no release, then resume
        step(mk(1'b0, 2'b01, 2'b00, 8'h10, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0), "stall_idle");
        step(mk(1'b0, 2'b01, 2'b00, 8'h11, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'h11, 1'b1), "stall_beat0");
        for (int c = 0; c < 5; c++)
            step(mk(1'b0, 2'b01, 2'b00, 8'h22, 8'h00, 1'b1, 2'b01, 2'b00, 1'b0, 8'h00, 1'b1),
                 $sformatf("stall_full[%0d]", c));
        step(mk(1'b0, 2'b01, 2'b00, 8'h22, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'h22, 1'b1), "stall_resume");
        step(mk(1'b0, 2'b01, 2'b01, 8'h33, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'h33, 1'b1), "stall_last");
`ifdef FIFO_ARB_STALL_CNT_EN
        n_vec++;
        if (stall_cnt !== 16'd5) begin
            n_err++;
            $display("FAIL stall_cnt: got %0d, want 5", stall_cnt);
        end
        stall_clr = 1'b1;
        @(negedge W_CLK);
        stall_clr = 1'b0;
        n_vec++;
        if (stall_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL stall_clr: got %0d, want 0", stall_cnt);
        end
`endif
        // req1 granted with valid already gone: released after exactly 15 idle cycles, req0 next
        step(mk(1'b0, 2'b10, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0), "tmo_pick1");
        for (int c = 0; c < 15; c++)
            step(mk(1'b0, 2'b01, 2'b00, 8'h5A, 8'h00, 1'b0, 2'b10, 2'b10, 1'b0, 8'h00, 1'b1),
                 $sformatf("tmo_hold[%0d]", c));
        step(mk(1'b0, 2'b01, 2'b00, 8'h5A, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0), "tmo_released");
        step(mk(1'b0, 2'b01, 2'b01, 8'h5A, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'h5A, 1'b1), "tmo_req0");
        // reset mid-burst abandons it and restarts arbitration from rr_ptr=0
        step(mk(1'b0, 2'b01, 2'b00, 8'h60, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0), "rst_idle");
        step(mk(1'b0, 2'b01, 2'b00, 8'h61, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'h61, 1'b1), "rst_beat0");
        step(mk(1'b0, 2'b01, 2'b00, 8'h62, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'h62, 1'b1), "rst_beat1");
        step(mk(1'b1, 2'b01, 2'b00, 8'h63, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0), "rst_assert");
        step(mk(1'b0, 2'b11, 2'b00, 8'h71, 8'h72, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0), "rst_rearb");
        step(mk(1'b0, 2'b11, 2'b01, 8'h71, 8'h72, 1'b0, 2'b01, 2'b01, 1'b1, 8'h71, 1'b1), "rst_ptr0");
        step(mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0), "rst_done");
        // four requesters, valids 1010: order 0010, 1000, 0010
        step4(4'b1010, 4'b0000, 1'b0, 8'h00, "rr4_idle0");
        step4(4'b1010, 4'b0010, 1'b1, 8'h22, "rr4_grant1");
        step4(4'b1010, 4'b0000, 1'b0, 8'h00, "rr4_idle1");
        step4(4'b1010, 4'b1000, 1'b1, 8'h44, "rr4_grant3");
        step4(4'b1010, 4'b0000, 1'b0, 8'h00, "rr4_idle2");
        step4(4'b1010, 4'b0010, 1'b1, 8'h22, "rr4_grant1b");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
